// File: rtl/shift_pkg.sv
// Shared constants for the arithmetic shifter and its inverse (shift_restorer):
// direction encoding, field positions inside the 4-bit B control word, FSM states.
package shift_pkg;

    localparam int DEF_SHW = 2;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // B = {fill, amount[DEF_SHW-1:0], direction}
    localparam int B_DIR    = 0;
    localparam int B_AMT_LO = 1;
    localparam int B_AMT_HI = DEF_SHW;
    localparam int B_FILL   = DEF_SHW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_restorer_step.sv
// One-position undo of a shift on the double-width working register, plus the bit
// that falls out (which must equal the fill bit for a consistent input).
module shift_restorer_step
    import shift_pkg::*;
#(
    parameter int W2 = 8
) (
    input  logic [W2-1:0] w,
    input  logic          dir,
    output logic [W2-1:0] w_next,
    output logic          bit_out
);

    always_comb begin
        w_next  = w;
        bit_out = 1'b0;
        if (dir == DIR_LEFT) begin
            w_next  = {1'b0, w[W2-1:1]};
            bit_out = w[0];
        end else begin
            w_next  = {w[W2-2:0], 1'b0};
            bit_out = w[W2-1];
        end
    end

endmodule

// File: rtl/shift_restorer.sv
// Reconstructs the pre-shift operand A from shifted result X, spill word Y and control B,
// one bit position per clock, flagging fill bits or residue that disagree with B.
module shift_restorer
    import shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SHW   = DEF_SHW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   X,
    input  logic [WIDTH-1:0]   Y,
    input  logic [SHW+1:0]     B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   A,
    output logic               err
);

    localparam int W2 = 2 * WIDTH;

    state_t             state_reg;
    logic [W2-1:0]      w_reg;
    logic [SHW-1:0]     cnt_reg;
    logic               fill_reg;
    logic               dir_reg;
    logic               sticky_reg;
    logic [WIDTH-1:0]   a_reg;
    logic               err_reg;
    logic               out_valid_reg;
    logic               in_ready_reg;

    logic [W2-1:0]      w_next;
    logic               bit_out;
    logic [SHW-1:0]     b_amt;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   residue;

    assign b_amt = B[B_AMT_HI:B_AMT_LO];

    shift_restorer_step #(
        .W2 (W2)
    ) u_step (
        .w       (w_reg),
        .dir     (dir_reg),
        .w_next  (w_next),
        .bit_out (bit_out)
    );

    // Once all positions are undone, one half holds A and the other must be empty.
    always_comb begin
        if (dir_reg == DIR_RIGHT) begin
            a_sel   = w_reg[W2-1:WIDTH];
            residue = w_reg[WIDTH-1:0];
        end else begin
            a_sel   = w_reg[WIDTH-1:0];
            residue = w_reg[W2-1:WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            w_reg         <= '0;
            cnt_reg       <= '0;
            fill_reg      <= 1'b0;
            dir_reg       <= DIR_LEFT;
            sticky_reg    <= 1'b0;
            a_reg         <= '0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        dir_reg      <= B[B_DIR];
                        fill_reg     <= B[B_FILL];
                        cnt_reg      <= b_amt;
                        sticky_reg   <= 1'b0;
                        w_reg        <= (B[B_DIR] == DIR_LEFT) ? {Y, X} : {X, Y};
                        in_ready_reg <= 1'b0;
                        state_reg    <= (b_amt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    w_reg   <= w_next;
                    cnt_reg <= cnt_reg - SHW'(1);
                    if (bit_out != fill_reg) begin
                        sticky_reg <= 1'b1;
                    end
                    if (cnt_reg == SHW'(1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle registers the result; afterwards wait for the consumer.
                    if (!out_valid_reg) begin
                        a_reg         <= a_sel;
                        err_reg       <= sticky_reg | (|residue);
                        out_valid_reg <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign A         = a_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_shift_restorer.sv
// Self-checking bench for shift_restorer: directed cases with literal expectations plus
// randomized requests checked every cycle against an arithmetic reference model.
module tb_shift_restorer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] X = '0;
    logic [3:0] Y = '0;
    logic [3:0] B = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] A;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    shift_restorer #(.WIDTH(4), .SHW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A         (A),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: restore A arithmetically from the spec's description of W.
    function automatic void ref_restore(input logic [3:0] x, input logic [3:0] y,
                                        input logic [3:0] b,
                                        output logic [3:0] a, output logic e);
        int s, w, mask, fillv, edge_bits, res;
        s     = int'(b[2:1]);
        mask  = (1 << s) - 1;
        fillv = b[3] ? mask : 0;
        if (b[0] == 1'b0) begin
            w         = int'({y, x});
            edge_bits = w & mask;
            a         = 4'((w >> s) & 15);
            res       = (w >> s) >> 4;
        end else begin
            w         = int'({x, y});
            edge_bits = w >> (8 - s);
            a         = 4'(((w << s) >> 4) & 15);
            res       = (w << s) & 15;
        end
        e = (edge_bits != fillv) || (res != 0);
    endfunction

    // Cycle model: accept only when idle, result s+1 cycles later, hold until taken.
    logic       m_ready, m_valid, m_err, p_err;
    logic [3:0] m_a, p_a;
    int         m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready <= 1'b1;
            m_valid <= 1'b0;
            m_a     <= '0;
            m_err   <= 1'b0;
            m_cnt   <= 0;
        end else if (m_ready) begin
            if (in_valid) begin
                logic [3:0] ta;
                logic       te;
                ref_restore(X, Y, B, ta, te);
                p_a     <= ta;
                p_err   <= te;
                m_cnt   <= int'(B[2:1]) + 1;
                m_ready <= 1'b0;
            end
        end else if (!m_valid) begin
            if (m_cnt == 1) begin
                m_valid <= 1'b1;
                m_a     <= p_a;
                m_err   <= p_err;
            end
            m_cnt <= m_cnt - 1;
        end else if (out_ready) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
        end
    end

    always @(negedge clk) begin
        check("cyc_in_ready", int'(in_ready), int'(m_ready));
        check("cyc_out_valid", int'(out_valid), int'(m_valid));
        check("cyc_A", int'(A), int'(m_a));
        check("cyc_err", int'(err), int'(m_err));
    end

    // Issue one request from a negedge; returns accept-to-out_valid latency in cycles.
    task automatic run_req(input logic [3:0] x, input logic [3:0] y, input logic [3:0] b,
                           input int hold, input bit poke_done, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("wait_in_ready_timeout", 0, 1);
        X = x; Y = y; B = b; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("wait_out_valid_timeout", 0, 1);
        if (poke_done) begin
            X = 4'hF; Y = 4'hF; B = 4'h0; in_valid = 1'b1;
        end
        repeat (hold) @(negedge clk);
        in_valid = 1'b0;
        $display("req X=%b Y=%b B=%b -> A=%b err=%b lat=%0d", x, y, b, A, err, lat);
    endtask

    task automatic finish_req();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [3:0] ea, ra, x, y, b;
        logic       ee;
        int         s, w, af;
        logic       f, d;

        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_A", int'(A), 0);
        check("rst_err", int'(err), 0);
        rst = 1'b0;
        @(negedge clk);

        run_req(4'b1111, 4'b0010, 4'b1100, 0, 1'b0, lat);
        check("left_lat", lat, 3);
        check("left_A", int'(A), 4'b1011);
        check("left_err", int'(err), 0);
        finish_req();

        run_req(4'b0011, 4'b0000, 4'b0011, 0, 1'b0, lat);
        check("right_lat", lat, 2);
        check("right_A", int'(A), 4'b0110);
        check("right_err", int'(err), 0);
        finish_req();

        run_req(4'b1001, 4'b0000, 4'b0000, 2, 1'b1, lat);
        check("zero_lat", lat, 1);
        check("zero_A", int'(A), 4'b1001);
        check("zero_err", int'(err), 0);
        check("zero_done_ignores_in_valid", int'(in_ready), 0);
        finish_req();

        run_req(4'b1110, 4'b0010, 4'b1100, 0, 1'b0, lat);
        check("fill_A", int'(A), 4'b1011);
        check("fill_err", int'(err), 1);
        finish_req();

        run_req(4'b1111, 4'b1010, 4'b1100, 0, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_A", int'(A), 4'b1011);
            check("bp_err", int'(err), 1);
            check("bp_in_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        finish_req();
        check("bp_ready_after", int'(in_ready), 1);

        X = 4'b1010; Y = 4'b0000; B = 4'b0111; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_A", int'(A), 0);
        check("midrst_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_req(4'b1111, 4'b0010, 4'b1100, 0, 1'b0, lat);
        check("post_rst_A", int'(A), 4'b1011);
        check("post_rst_err", int'(err), 0);
        finish_req();

        // Random: half built from a known A so err=0 paths are exercised, half raw.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                af = int'($urandom_range(0, 15));
                s  = int'($urandom_range(0, 3));
                f  = 1'($urandom_range(0, 1));
                d  = 1'($urandom_range(0, 1));
                if (!d) begin
                    w = ((af << s) | (f ? ((1 << s) - 1) : 0)) & 255;
                    y = 4'(w >> 4); x = 4'(w & 15);
                end else begin
                    w = ((f ? ((1 << s) - 1) : 0) << (8 - s)) | (af << (4 - s));
                    w = w & 255;
                    x = 4'(w >> 4); y = 4'(w & 15);
                end
                b = {f, 2'(s), d};
                run_req(x, y, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), lat);
                check("rnd_built_A", int'(A), af);
                check("rnd_built_err", int'(err), 0);
            end else begin
                x = 4'($urandom_range(0, 15));
                y = 4'($urandom_range(0, 15));
                b = 4'($urandom_range(0, 15));
                ref_restore(x, y, b, ea, ee);
                run_req(x, y, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), lat);
                ra = A;
                check("rnd_A", int'(ra), int'(ea));
                check("rnd_err", int'(err), int'(ee));
            end
            check("rnd_lat", lat, int'(b[2:1]) + 1);
            finish_req();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
